mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/InstructionStruct.sv | 10 +
 rtl/arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/InstructionStruct.sv
// Shared widths and enums for the memory arbiter slice.
package InstructionStruct;

   localparam int unsigned DWIDTH    = 32;
   localparam int unsigned CPUAWIDTH = 16;

   typedef enum logic [1:0] {IDLE, BUS, RESP} arb_state_t;
   typedef enum logic {SRC_FETCH, SRC_DATA} arb_src_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant decision between fetch and data requesters.
// MEM_ARB_RR_EN selects alternating grants on ties; otherwise data always wins.
module arb_pick
   import InstructionStruct::*;
(
   input  logic     if_req,
   input  logic     d_req,
   input  arb_src_t ptr,
   output arb_src_t src,
   output logic     gnt
);

   assign gnt = if_req | d_req;

`ifdef MEM_ARB_RR_EN
   // ptr holds the last winner; a tie goes to the other side.
   always_comb begin
      src = SRC_DATA;
      if (if_req && d_req) begin
         src = (ptr == SRC_DATA) ? SRC_FETCH : SRC_DATA;
      end else if (if_req) begin
         src = SRC_FETCH;
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ptr;

   always_comb begin
      src = SRC_DATA;
      if (if_req && !d_req) begin
         src = SRC_FETCH;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory bus, LAT cycles per access.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed data priority.
module mem_arbiter
   import InstructionStruct::*;
#(
   parameter int unsigned LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_req,
   input  logic [CPUAWIDTH-1:0] if_addr,
   output logic                 if_ack,
   output logic [DWIDTH-1:0]    if_rdata,
   input  logic                 d_req,
   input  logic                 d_rw,
   input  logic [CPUAWIDTH-1:0] d_addr,
   input  logic [DWIDTH-1:0]    d_wdata,
   output logic                 d_ack,
   output logic [DWIDTH-1:0]    d_rdata,
   inout  wire  [DWIDTH-1:0]    mem_data,
   output logic [CPUAWIDTH-1:0] mem_addr,
   output logic                 mem_rw,
   output logic                 mem_valid
);

   localparam logic [3:0] LatM1 = 4'(LAT - 1);

   arb_state_t           state_q, state_d;
   arb_src_t             src_q, pick_src, ptr;
   logic                 pick_gnt, grant, last_beat;
   logic [3:0]           cnt_q;
   logic [CPUAWIDTH-1:0] addr_q;
   logic                 rw_q;
   logic [DWIDTH-1:0]    wdata_q, if_rdata_q, d_rdata_q;

   arb_pick u_pick (
      .if_req (if_req),
      .d_req  (d_req),
      .ptr    (ptr),
      .src    (pick_src),
      .gnt    (pick_gnt)
   );

   // Requesters are only looked at in IDLE, so in-flight transactions are immune to input changes.
   assign grant     = (state_q == IDLE) && pick_gnt;
   assign last_beat = (state_q == BUS) && (cnt_q == 4'd0);

`ifdef MEM_ARB_RR_EN
   arb_src_t ptr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= SRC_FETCH;
      end else if (grant) begin
         ptr_q <= pick_src;
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = SRC_FETCH;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_gnt) state_d = BUS;
         BUS:     if (cnt_q == 4'd0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= 4'd0;
         src_q      <= SRC_FETCH;
         addr_q     <= '0;
         rw_q       <= 1'b1;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (grant) begin
            src_q <= pick_src;
            cnt_q <= LatM1;
            if (pick_src == SRC_DATA) begin
               addr_q  <= d_addr;
               rw_q    <= d_rw;
               wdata_q <= d_wdata;
            end else begin
               addr_q <= if_addr;
               rw_q   <= 1'b1;
            end
         end else if ((state_q == BUS) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
         end

         if (last_beat && rw_q) begin
            if (src_q == SRC_DATA) begin
               d_rdata_q <= mem_data;
            end else begin
               if_rdata_q <= mem_data;
            end
         end
      end
   end

   always_comb begin
      mem_valid = 1'b0;
      mem_rw    = 1'b1;
      if_ack    = 1'b0;
      d_ack     = 1'b0;
      case (state_q)
         BUS: begin
            mem_valid = 1'b1;
            mem_rw    = rw_q;
         end
         RESP: begin
            if_ack = (src_q == SRC_FETCH);
            d_ack  = (src_q == SRC_DATA);
         end
         default: ;
      endcase
   end

   assign mem_addr = addr_q;
   assign mem_data = ((state_q == BUS) && !rw_q) ? wdata_q : 'z;
   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one LAT=1 and one LAT=3 instance, ack scoreboard per instance.
module tb_mem_arbiter;
   import InstructionStruct::*;

   typedef struct {
      arb_src_t          src;
      int                cyc;
      logic [DWIDTH-1:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb1[$];
   exp_t sb3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic                 if_req1, if_ack1, d_req1, d_rw1, d_ack1, mem_rw1, mem_valid1;
   logic [CPUAWIDTH-1:0] if_addr1, d_addr1, mem_addr1;
   logic [DWIDTH-1:0]    if_rdata1, d_wdata1, d_rdata1, rd_val1;
   wire  [DWIDTH-1:0]    mem_data1;

   logic                 if_req3, if_ack3, d_req3, d_rw3, d_ack3, mem_rw3, mem_valid3;
   logic [CPUAWIDTH-1:0] if_addr3, d_addr3, mem_addr3;
   logic [DWIDTH-1:0]    if_rdata3, d_wdata3, d_rdata3, rd_val3;
   wire  [DWIDTH-1:0]    mem_data3;

   // Memory model: returns rd_val whenever a read strobe is on the bus.
   assign mem_data1 = (mem_valid1 && mem_rw1) ? rd_val1 : 'z;
   assign mem_data3 = (mem_valid3 && mem_rw3) ? rd_val3 : 'z;

   mem_arbiter #(.LAT(1)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req1),
      .if_addr   (if_addr1),
      .if_ack    (if_ack1),
      .if_rdata  (if_rdata1),
      .d_req     (d_req1),
      .d_rw      (d_rw1),
      .d_addr    (d_addr1),
      .d_wdata   (d_wdata1),
      .d_ack     (d_ack1),
      .d_rdata   (d_rdata1),
      .mem_data  (mem_data1),
      .mem_addr  (mem_addr1),
      .mem_rw    (mem_rw1),
      .mem_valid (mem_valid1)
   );

   mem_arbiter #(.LAT(3)) u_dut3 (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req3),
      .if_addr   (if_addr3),
      .if_ack    (if_ack3),
      .if_rdata  (if_rdata3),
      .d_req     (d_req3),
      .d_rw      (d_rw3),
      .d_addr    (d_addr3),
      .d_wdata   (d_wdata3),
      .d_ack     (d_ack3),
      .d_rdata   (d_rdata3),
      .mem_data  (mem_data3),
      .mem_addr  (mem_addr3),
      .mem_rw    (mem_rw3),
      .mem_valid (mem_valid3)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input arb_src_t src, input int c, input logic [DWIDTH-1:0] rd);
      exp_t e;
      e.src   = src;
      e.cyc   = c;
      e.rdata = rd;
      return e;
   endfunction

   // Advance one clock, then score any ack against the front of each queue.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      check("ack_excl1", 64'(if_ack1 && d_ack1), 64'h0);
      check("ack_excl3", 64'(if_ack3 && d_ack3), 64'h0);
      if (if_ack1 || d_ack1) begin
         if (sb1.size() == 0) begin
            check("unexp_ack1", 64'({if_ack1, d_ack1}), 64'h0);
         end else begin
            e = sb1.pop_front();
            check("src1", 64'(d_ack1), 64'(e.src == SRC_DATA));
            check("ack_cyc1", 64'(cyc), 64'(e.cyc));
            check("rdata1", 64'(d_ack1 ? d_rdata1 : if_rdata1), 64'(e.rdata));
         end
      end
      if (if_ack3 || d_ack3) begin
         if (sb3.size() == 0) begin
            check("unexp_ack3", 64'({if_ack3, d_ack3}), 64'h0);
         end else begin
            e = sb3.pop_front();
            check("src3", 64'(d_ack3), 64'(e.src == SRC_DATA));
            check("ack_cyc3", 64'(cyc), 64'(e.cyc));
            check("rdata3", 64'(d_ack3 ? d_rdata3 : if_rdata3), 64'(e.rdata));
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset   = 1'b1;
      if_req1 = 1'b0; if_addr1 = '0; d_req1 = 1'b0; d_rw1 = 1'b1; d_addr1 = '0; d_wdata1 = '0;
      if_req3 = 1'b0; if_addr3 = '0; d_req3 = 1'b0; d_rw3 = 1'b1; d_addr3 = '0; d_wdata3 = '0;
      rd_val1 = '0;   rd_val3 = '0;

      // Reset state
      @(posedge clk);
      #1;
      check("rst_valid3", 64'(mem_valid3), 64'h0);
      check("rst_rw3", 64'(mem_rw3), 64'h1);
      check("rst_addr3", 64'(mem_addr3), 64'h0);
      check("rst_acks3", 64'({if_ack3, d_ack3}), 64'h0);
      check("rst_rdata3", {if_rdata3, d_rdata3}, 64'h0);
      check("rst_valid1", 64'(mem_valid1), 64'h0);
      reset = 1'b0;
      tick();

      // LAT=1 data write
      d_req1 = 1'b1; d_rw1 = 1'b0; d_addr1 = 16'h0040; d_wdata1 = 32'hDEADBEEF;
      sb1.push_back(mk(SRC_DATA, cyc + 2, 32'h0));
      tick();
      check("wr_valid", 64'(mem_valid1), 64'h1);
      check("wr_rw", 64'(mem_rw1), 64'h0);
      check("wr_addr", 64'(mem_addr1), 64'h0040);
      check("wr_data", 64'(mem_data1), 64'hDEADBEEF);
      tick();
      check("wr_resp_valid", 64'(mem_valid1), 64'h0);
      d_req1 = 1'b0; d_rw1 = 1'b1;

      // LAT=3 fetch read
      rd_val3 = 32'h12345678; d_wdata3 = 32'hFFFF0000;
      if_req3 = 1'b1; if_addr3 = 16'h0100;
      sb3.push_back(mk(SRC_FETCH, cyc + 4, 32'h12345678));
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rd_valid", 64'(mem_valid3), 64'h1);
         check("rd_rw", 64'(mem_rw3), 64'h1);
         check("rd_addr", 64'(mem_addr3), 64'h0100);
         check("rd_bus", 64'(mem_data3), 64'h12345678);
      end
      tick();
      check("rd_resp_valid", 64'(mem_valid3), 64'h0);
      if_req3 = 1'b0;
      tick();

      // LAT=3 write with inputs changing during BUS
      d_req3 = 1'b1; d_rw3 = 1'b0; d_addr3 = 16'h0040; d_wdata3 = 32'hA5A50001;
      sb3.push_back(mk(SRC_DATA, cyc + 4, 32'h0));
      tick();
      d_addr3 = 16'h0080; d_wdata3 = 32'h0BADF00D; d_rw3 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("hold_valid", 64'(mem_valid3), 64'h1);
         check("hold_addr", 64'(mem_addr3), 64'h0040);
         check("hold_rw", 64'(mem_rw3), 64'h0);
         check("hold_data", 64'(mem_data3), 64'hA5A50001);
         tick();
      end
      check("hold_resp_valid", 64'(mem_valid3), 64'h0);
      d_req3 = 1'b0;
      tick();

      // LAT=3 data read; fetch rdata must hold
      d_req3 = 1'b1; d_rw3 = 1'b1; d_addr3 = 16'h0200; rd_val3 = 32'hCAFEF00D;
      sb3.push_back(mk(SRC_DATA, cyc + 4, 32'hCAFEF00D));
      repeat (4) tick();
      d_req3 = 1'b0;
      check("if_rdata_hold", 64'(if_rdata3), 64'h12345678);
      tick();

      // Reset in the second BUS cycle of a fetch read
      if_req3 = 1'b1; if_addr3 = 16'h0104; rd_val3 = 32'h77777777;
      tick();
      tick();
      reset = 1'b1; if_req3 = 1'b0;
      #1;
      check("mid_rst_valid", 64'(mem_valid3), 64'h0);
      check("mid_rst_rw", 64'(mem_rw3), 64'h1);
      check("mid_rst_addr", 64'(mem_addr3), 64'h0);
      check("mid_rst_acks", 64'({if_ack3, d_ack3}), 64'h0);
      check("mid_rst_rdata", {if_rdata3, d_rdata3}, 64'h0);
      tick();
      reset = 1'b0;
      check("post_rst_valid", 64'(mem_valid3), 64'h0);
      tick();
      tick();

      // Reissue after reset: full latency from an IDLE start
      if_req3 = 1'b1; rd_val3 = 32'h0F0F0F0F;
      sb3.push_back(mk(SRC_FETCH, cyc + 4, 32'h0F0F0F0F));
      repeat (4) tick();
      if_req3 = 1'b0;
      tick();

      // Both requesters held high for four LAT=1 transactions
      if_req1 = 1'b1; d_req1 = 1'b1; d_rw1 = 1'b1;
      if_addr1 = 16'h0300; d_addr1 = 16'h0400; rd_val1 = 32'h5555AAAA;
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
         sb1.push_back(mk((k % 2 == 0) ? SRC_DATA : SRC_FETCH, cyc + 2 + 3 * k, 32'h5555AAAA));
`else
         sb1.push_back(mk(SRC_DATA, cyc + 2 + 3 * k, 32'h5555AAAA));
`endif
      end
      repeat (12) tick();
      if_req1 = 1'b0; d_req1 = 1'b0;
      repeat (3) tick();

      check("sb1_left", 64'(sb1.size()), 64'h0);
      check("sb3_left", 64'(sb3.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
